// File: rtl/uart_cmd_parser_pkg.sv
// Shared definitions for the receive-side command parser: datapath width,
// ASCII control characters, parser states and the ASCII-to-nibble decoder.
package uart_cmd_parser_pkg;

  localparam int unsigned SEQ_DP_WIDTH = 16;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_BS = 8'h08;

  typedef enum logic [1:0] {
    stEmpty,
    stAcc,
    stDiscard
  } parse_state_e;

  // Returns {legal, nibble}; inverse of the TX-side nibble-to-ASCII mapping.
  function automatic logic [4:0] fnASCII2Nib(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39) begin
      r = {1'b1, c[3:0]};
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
      r = {1'b1, c[3:0] + 4'd9};
    end
    return r;
  endfunction

  function automatic logic fnIsTerm(input logic [7:0] c);
    return (c == ASCII_CR) || (c == ASCII_LF);
  endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Converts a CR/LF-terminated line of ASCII hex digits from the UART receiver
// into one right-aligned command word on a valid/ready output register.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int unsigned DATA_W  = SEQ_DP_WIDTH,
  parameter int unsigned NUM_NIB = DATA_W / 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic [DATA_W-1:0] o_cmd,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output logic              o_err,
  output logic              o_overrun,
  output logic              o_busy
);

  localparam int unsigned CNT_W = $clog2(NUM_NIB + 1);

  parse_state_e      state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              complete;

  logic [DATA_W-1:0] cmd_q;
  logic              cmd_valid_q;
  logic              overrun_q;

  logic [4:0]        dec;
  logic              is_digit;
  logic              is_term;
  logic              is_bs;
  logic [3:0]        nib;

  // Classify the incoming byte.
  always_comb begin
    dec      = fnASCII2Nib(i_rx_data);
    is_digit = dec[4];
    nib      = dec[3:0];
    is_term  = fnIsTerm(i_rx_data);
    is_bs    = (i_rx_data == ASCII_BS);
  end

  // Line parser next state: accumulator, digit count, error pulse, completion.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    complete = 1'b0;
    if (i_rx_valid) begin
      case (state_q)
        stEmpty: begin
          if (is_digit) begin
            acc_d   = DATA_W'(nib);
            cnt_d   = CNT_W'(1);
            state_d = stAcc;
          end else if (!is_term && !is_bs) begin
            err_d   = 1'b1;
            state_d = stDiscard;
          end
        end
        stAcc: begin
          if (is_digit) begin
            if (cnt_q == CNT_W'(NUM_NIB)) begin
              err_d   = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = stDiscard;
            end else begin
              acc_d = (acc_q << 4) | DATA_W'(nib);
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (is_bs) begin
            acc_d = acc_q >> 4;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = stEmpty;
            end
          end else if (is_term) begin
            complete = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = stEmpty;
          end else begin
            err_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = stDiscard;
          end
        end
        stDiscard: begin
          if (is_term) begin
            state_d = stEmpty;
          end
        end
        default: begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = stEmpty;
        end
      endcase
    end
  end

  // Parser state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= stEmpty;
      acc_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Single-entry output register; a word completing into a full, unaccepted
  // register is dropped and flagged instead of overwriting the held word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (complete) begin
        if (!cmd_valid_q || i_cmd_ready) begin
          cmd_q       <= acc_q;
          cmd_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (cmd_valid_q && i_cmd_ready) begin
        cmd_valid_q <= 1'b0;
      end
    end
  end

  assign o_cmd       = cmd_q;
  assign o_cmd_valid = cmd_valid_q;
  assign o_err       = err_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = (state_q != stEmpty);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser against a line-level reference model.
module tb_uart_cmd_parser;

  localparam int unsigned DW  = 16;
  localparam int unsigned NIB = 4;

  typedef byte unsigned bq_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    i_rx_data;
  logic          i_rx_valid;
  logic [DW-1:0] o_cmd;
  logic          o_cmd_valid;
  logic          i_cmd_ready;
  logic          o_err;
  logic          o_overrun;
  logic          o_busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: pending digits of the current line, discard flag and
  // the single output slot.
  int          m_digs[$];
  bit          m_discard;
  bit [DW-1:0] m_cmd;
  bit          m_valid;
  bit          m_err;
  bit          m_ovr;

  uart_cmd_parser #(.DATA_W(DW), .NUM_NIB(NIB)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .o_cmd      (o_cmd),
    .o_cmd_valid(o_cmd_valid),
    .i_cmd_ready(i_cmd_ready),
    .o_err      (o_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  function automatic int nib_of(input byte unsigned c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 65 + 10;
    if (c >= "a" && c <= "f") return int'(c) - 97 + 10;
    return -1;
  endfunction

  function automatic bit m_busy();
    return m_discard || (m_digs.size() != 0);
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic model_reset();
    m_digs.delete();
    m_discard = 0;
    m_cmd     = '0;
    m_valid   = 0;
    m_err     = 0;
    m_ovr     = 0;
  endtask

  task automatic model_step(input bit v, input byte unsigned c, input bit rdy);
    bit complete;
    int n;
    int unsigned val;
    complete = 0;
    val      = 0;
    m_err    = 0;
    m_ovr    = 0;
    if (v) begin
      n = nib_of(c);
      if (m_discard) begin
        if (c == 8'h0D || c == 8'h0A) m_discard = 0;
      end else if (n >= 0) begin
        if (m_digs.size() == NIB) begin
          m_err = 1; m_discard = 1; m_digs.delete();
        end else begin
          m_digs.push_back(n);
        end
      end else if (c == 8'h08) begin
        if (m_digs.size() > 0) void'(m_digs.pop_back());
      end else if (c == 8'h0D || c == 8'h0A) begin
        if (m_digs.size() > 0) begin
          complete = 1;
          foreach (m_digs[i]) val = val * 16 + m_digs[i];
          m_digs.delete();
        end
      end else begin
        m_err = 1; m_discard = 1; m_digs.delete();
      end
    end
    if (complete) begin
      if (!m_valid || rdy) begin
        m_cmd   = val[DW-1:0];
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cycle(input bit v, input byte unsigned c, input bit rdy);
    i_cmd_ready = rdy;
    i_rx_valid  = v;
    i_rx_data   = c;
    if (rst) model_reset();
    else model_step(v, c, rdy);
    @(posedge clk);
    #1;
    i_rx_valid = 1'b0;
    i_rx_data  = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(0, 8'h00, 0);
    cycle(1, "5", 0);
    n_checks++;
    if ({o_cmd, o_cmd_valid, o_err, o_overrun, o_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cmd=%h vld/err/ovr/busy=%b%b%b%b exp all 0",
               o_cmd, o_cmd_valid, o_err, o_overrun, o_busy);
    end
    rst = 1'b0;
    cycle(0, 8'h00, 1);
  endtask

  task automatic test_basic();
    bq_t q;
    int vcnt;
    q = str2q("12AB");
    q.push_back(8'h0D);
    vcnt = 0;
    for (int k = 0; k < 2 * q.size() + 2; k++) begin
      if (k % 2 == 0 && k / 2 < q.size()) cycle(1, q[k/2], 1);
      else cycle(0, 8'h00, 1);
      n_checks++;
      if ({o_cmd_valid, o_err, o_overrun, o_busy} !== {m_valid, m_err, m_ovr, m_busy()}) begin
        n_fail++;
        $display("FAIL basic_flags k=%0d: vld/err/ovr/busy got %b exp %b", k,
                 {o_cmd_valid, o_err, o_overrun, o_busy}, {m_valid, m_err, m_ovr, m_busy()});
      end
      if (o_cmd_valid) begin
        vcnt++;
        n_checks++;
        if (o_cmd !== 16'h12AB) begin
          n_fail++;
          $display("FAIL basic_cmd: got %h exp 12ab", o_cmd);
        end
      end
    end
    n_checks++;
    if (vcnt != 1) begin
      n_fail++;
      $display("FAIL basic_valid_cycles: got %0d exp 1", vcnt);
    end
  endtask

  task automatic test_hold();
    bq_t q;
    q = str2q("7f");
    q.push_back(8'h0A);
    foreach (q[i]) begin
      cycle(1, q[i], 0);
      cycle(0, 8'h00, 0);
    end
    for (int k = 0; k < 10; k++) begin
      cycle(0, 8'h00, 0);
      n_checks++;
      if ({o_cmd_valid, o_cmd} !== {1'b1, 16'h007F}) begin
        n_fail++;
        $display("FAIL hold_stable k=%0d: got vld=%b cmd=%h exp vld=1 cmd=007f", k, o_cmd_valid, o_cmd);
      end
    end
    cycle(0, 8'h00, 1);
    n_checks++;
    if (o_cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_drop: got vld=%b exp 0", o_cmd_valid);
    end
  endtask

  task automatic test_illegal();
    bq_t q;
    int ecnt;
    bit last_g;
    q = str2q("12G4");
    q.push_back(8'h0D);
    q = {q, str2q("5")};
    q.push_back(8'h0D);
    ecnt   = 0;
    last_g = 0;
    foreach (q[i]) begin
      cycle(1, q[i], 1);
      n_checks++;
      if ({o_cmd_valid, o_err, o_overrun, o_busy} !== {m_valid, m_err, m_ovr, m_busy()}) begin
        n_fail++;
        $display("FAIL illegal_flags i=%0d: vld/err/ovr/busy got %b exp %b", i,
                 {o_cmd_valid, o_err, o_overrun, o_busy}, {m_valid, m_err, m_ovr, m_busy()});
      end
      if (o_err) begin
        ecnt++;
        n_checks++;
        if (q[i] != "G") begin
          n_fail++;
          $display("FAIL illegal_err_pos: got err after byte %h exp after 'G'", q[i]);
        end
      end
      if (o_cmd_valid) begin
        n_checks++;
        if (o_cmd !== 16'h0005) begin
          n_fail++;
          $display("FAIL illegal_cmd: got %h exp 0005", o_cmd);
        end
      end
    end
    cycle(0, 8'h00, 1);
    n_checks++;
    if (ecnt != 1) begin
      n_fail++;
      $display("FAIL illegal_err_count: got %0d exp 1", ecnt);
    end
  endtask

  task automatic test_overflow();
    bq_t q;
    int ecnt;
    q = str2q("123456");
    q.push_back(8'h0D);
    q.push_back(8'h0D);
    ecnt = 0;
    foreach (q[i]) begin
      cycle(1, q[i], 1);
      cycle(0, 8'h00, 1);
      n_checks++;
      if ({o_cmd_valid, o_err, o_overrun, o_busy} !== {m_valid, m_err, m_ovr, m_busy()}) begin
        n_fail++;
        $display("FAIL overflow_flags i=%0d: vld/err/ovr/busy got %b exp %b", i,
                 {o_cmd_valid, o_err, o_overrun, o_busy}, {m_valid, m_err, m_ovr, m_busy()});
      end
    end
    // err is only visible on the cycle right after the 5th digit
    n_checks++;
    if (o_cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_no_word: got vld=%b exp 0", o_cmd_valid);
    end
    q = str2q("12345");
    foreach (q[i]) begin
      cycle(1, q[i], 1);
      if (o_err) ecnt++;
    end
    cycle(1, 8'h0D, 1);
    n_checks++;
    if (ecnt != 1 || o_cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_err_once: got err_count=%0d vld=%b exp 1 and 0", ecnt, o_cmd_valid);
    end
  endtask

  task automatic test_backspace();
    bq_t q;
    bit [DW-1:0] exp_words[$];
    bit [DW-1:0] got_words[$];
    q = str2q("ABC");
    q.push_back(8'h08);
    q = {q, str2q("9")};
    q.push_back(8'h0D);
    q.push_back(8'h08);
    q.push_back(8'h08);
    q = {q, str2q("1")};
    q.push_back(8'h0D);
    exp_words = '{16'h0AB9, 16'h0001};
    foreach (q[i]) begin
      cycle(1, q[i], 1);
      n_checks++;
      if ({o_cmd_valid, o_err, o_overrun, o_busy} !== {m_valid, m_err, m_ovr, m_busy()}) begin
        n_fail++;
        $display("FAIL bs_flags i=%0d: vld/err/ovr/busy got %b exp %b", i,
                 {o_cmd_valid, o_err, o_overrun, o_busy}, {m_valid, m_err, m_ovr, m_busy()});
      end
      if (o_cmd_valid) got_words.push_back(o_cmd);
    end
    cycle(0, 8'h00, 1);
    n_checks++;
    if (got_words != exp_words) begin
      n_fail++;
      $display("FAIL bs_words: got %0d words (first %h) exp 0ab9,0001", got_words.size(),
               got_words.size() > 0 ? got_words[0] : 16'h0);
    end
  endtask

  task automatic test_overrun();
    bq_t q;
    int ocnt;
    q = str2q("1");
    q.push_back(8'h0D);
    q = {q, str2q("2")};
    q.push_back(8'h0D);
    ocnt = 0;
    foreach (q[i]) begin
      cycle(1, q[i], 0);
      cycle(0, 8'h00, 0);
      if (o_overrun) ocnt++;
      n_checks++;
      if ({o_cmd_valid, o_err, o_overrun, o_busy} !== {m_valid, m_err, m_ovr, m_busy()}) begin
        n_fail++;
        $display("FAIL overrun_flags i=%0d: vld/err/ovr/busy got %b exp %b", i,
                 {o_cmd_valid, o_err, o_overrun, o_busy}, {m_valid, m_err, m_ovr, m_busy()});
      end
    end
    cycle(1, "3", 0);
    cycle(1, 8'h0D, 0);
    n_checks++;
    if (o_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_pulse: got %b exp 1", o_overrun);
    end
    cycle(0, 8'h00, 0);
    n_checks++;
    if (ocnt != 0 || {o_overrun, o_cmd_valid, o_cmd} !== {1'b0, 1'b1, 16'h0001}) begin
      n_fail++;
      $display("FAIL overrun_hold: got early=%0d ovr=%b vld=%b cmd=%h exp 0 0 1 0001",
               ocnt, o_overrun, o_cmd_valid, o_cmd);
    end
    cycle(0, 8'h00, 1);
  endtask

  task automatic test_reset_midline();
    bit seen;
    cycle(1, "1", 1);
    cycle(1, "2", 1);
    rst = 1'b1;
    cycle(0, 8'h00, 1);
    rst = 1'b0;
    n_checks++;
    if ({o_cmd, o_cmd_valid, o_err, o_overrun, o_busy} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got cmd=%h vld/err/ovr/busy=%b%b%b%b exp all 0",
               o_cmd, o_cmd_valid, o_err, o_overrun, o_busy);
    end
    seen = 0;
    cycle(1, "3", 1);
    cycle(1, 8'h0D, 1);
    n_checks++;
    if ({o_cmd_valid, o_cmd} !== {1'b1, 16'h0003}) begin
      n_fail++;
      $display("FAIL rst_mid_word: got vld=%b cmd=%h exp 1 0003", o_cmd_valid, o_cmd);
    end
    cycle(1, "4", 0);
    cycle(1, 8'h0D, 0);
    rst = 1'b1;
    cycle(0, 8'h00, 0);
    rst = 1'b0;
    n_checks++;
    if (o_cmd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_drop_held: got vld=%b exp 0", o_cmd_valid);
    end
  endtask

  // Random lines; gap=0 gives back-to-back strobes.
  task automatic run_random(input string name, input int lines, input bit gaps);
    byte unsigned c;
    int len;
    for (int l = 0; l < lines; l++) begin
      len = $urandom_range(0, 7);
      for (int j = 0; j <= len; j++) begin
        if (j == len) c = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
        else begin
          case ($urandom_range(0, 9))
            6: c = 8'h08;
            7: c = 8'h0D;
            8: c = 8'($urandom_range(0, 255));
            default: c = str2q("0123456789abcdefABCDEF")[$urandom_range(0, 21)];
          endcase
        end
        cycle(1, c, $urandom_range(0, 3) != 0);
        n_checks++;
        if ({o_cmd_valid, o_err, o_overrun, o_busy} !== {m_valid, m_err, m_ovr, m_busy()}) begin
          n_fail++;
          $display("FAIL %s_flags l=%0d byte=%h: vld/err/ovr/busy got %b exp %b", name, l, c,
                   {o_cmd_valid, o_err, o_overrun, o_busy}, {m_valid, m_err, m_ovr, m_busy()});
        end
        if (m_valid) begin
          n_checks++;
          if (o_cmd !== m_cmd) begin
            n_fail++;
            $display("FAIL %s_cmd l=%0d: got %h exp %h", name, l, o_cmd, m_cmd);
          end
        end
        if (gaps && $urandom_range(0, 1) != 0) cycle(0, 8'h00, $urandom_range(0, 1) != 0);
      end
    end
    cycle(0, 8'h00, 1);
  endtask

  task automatic test_random();
    run_random("random", 80, 1);
  endtask

  task automatic test_back_to_back();
    run_random("b2b", 80, 0);
  endtask

  initial begin
    rst         = 1'b0;
    i_rx_data   = 8'h00;
    i_rx_valid  = 1'b0;
    i_cmd_ready = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_basic();
    test_hold();
    test_illegal();
    test_overflow();
    test_backspace();
    test_overrun();
    test_reset_midline();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
